// File: rtl/data_mem_hs_if.sv
// Request/response handshake bundle for data_mem_hs.
// master = requester (MEM stage), slave = memory.
interface data_mem_hs_if #(
   parameter int unsigned XLEN   = 64,
   parameter int unsigned ADDR_W = 64
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [1:0]        req_size;
   logic              req_unsigned;
   logic [XLEN-1:0]   req_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [XLEN-1:0]   rsp_rdata;
   logic              rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/data_mem_hs.sv
// Big-endian byte-addressable data memory with valid/ready request and one-slot response.
// Optional macro MISALIGN_TRAP_EN turns misaligned accesses into error responses.
module data_mem_hs #(
   parameter int unsigned XLEN   = 64,
   parameter int unsigned DEPTH  = 64,
   parameter int unsigned ADDR_W = 64
) (
   input logic          clk,
   input logic          rst,
   data_mem_hs_if.slave bus
);
   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic {StEmpty, StFull} slot_e;

   logic [7:0]      mem [DEPTH];
   slot_e           state_q;
   logic            rsp_valid_q;
   logic [XLEN-1:0] rsp_rdata_q;
   logic            rsp_err_q;

   logic            accept;
   logic            fault;
   logic [3:0]      nbytes;
   logic [AW-1:0]   base;
   logic [7:0]      ben;
   logic [AW-1:0]   baddr [8];
   logic [7:0]      rbyte [8];
   logic [7:0]      wbyte [8];
   logic [XLEN-1:0] load_val;
   logic [XLEN-1:0] rsp_next;
   logic            unused_addr;

   assign bus.req_ready = !rsp_valid_q | bus.rsp_ready;
   assign accept        = bus.req_valid & bus.req_ready & !rst;
   assign base          = bus.req_addr[AW-1:0];
   assign unused_addr   = ^bus.req_addr[ADDR_W-1:AW];

   always_comb begin
      nbytes = 4'd8;
      unique case (bus.req_size)
         2'b00:   nbytes = 4'd1;
         2'b01:   nbytes = 4'd4;
         2'b10:   nbytes = 4'd2;
         default: nbytes = 4'd8;
      endcase
   end

`ifdef MISALIGN_TRAP_EN
   assign fault = |(base[2:0] & 3'(nbytes - 4'd1));
`else
   assign fault = 1'b0;
`endif

   // Byte lane k addresses base+k, wrapping modulo DEPTH through the AW-bit add.
   always_comb begin
      for (int k = 0; k < 8; k++) begin
         ben[k]   = 4'(k) < nbytes;
         baddr[k] = base + AW'(k);
         rbyte[k] = mem[baddr[k]];
      end
   end

   always_comb begin
      int sh;
      sh = 0;
      for (int k = 0; k < 8; k++) begin
         wbyte[k] = 8'h00;
         if (ben[k]) begin
            sh       = 8 * (int'(nbytes) - 1 - k);
            wbyte[k] = 8'(bus.req_wdata >> sh);
         end
      end
   end

   // Seed with the extension bit, then shift bytes in MSB first.
   always_comb begin
      load_val = {XLEN{bus.req_unsigned ? 1'b0 : rbyte[0][7]}};
      for (int k = 0; k < 8; k++) begin
         if (ben[k]) begin
            load_val = {load_val[XLEN-9:0], rbyte[k]};
         end
      end
      rsp_next = (bus.req_we || fault) ? '0 : load_val;
   end

   always_ff @(posedge clk) begin
      if (accept && bus.req_we && !fault) begin
         for (int k = 0; k < 8; k++) begin
            if (ben[k]) begin
               mem[baddr[k]] <= wbyte[k];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StEmpty;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         case (state_q)
            StEmpty: begin
               if (accept) begin
                  state_q     <= StFull;
                  rsp_valid_q <= 1'b1;
                  rsp_rdata_q <= rsp_next;
                  rsp_err_q   <= fault;
               end
            end
            StFull: begin
               if (accept) begin
                  rsp_rdata_q <= rsp_next;
                  rsp_err_q   <= fault;
               end else if (bus.rsp_ready) begin
                  state_q     <= StEmpty;
                  rsp_valid_q <= 1'b0;
               end
            end
            default: begin
               state_q     <= StEmpty;
               rsp_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_data_mem_hs.sv
// Directed plus random checks of data_mem_hs against a byte-array reference model.
module tb_data_mem_hs;
   localparam int DEPTH = 64;
`ifdef MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   data_mem_hs_if #(.XLEN(64), .ADDR_W(64)) bus ();

   data_mem_hs #(.XLEN(64), .DEPTH(DEPTH), .ADDR_W(64)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [7:0]  ref_mem [DEPTH];
   bit          m_valid;
   logic [63:0] m_rdata;
   bit          m_err;
   int          n_assert;
   int          n_fail;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic void ref_access(input bit we, input logic [63:0] addr,
                                      input logic [1:0] size, input bit uns,
                                      input logic [63:0] wd, output logic [63:0] rd,
                                      output bit er);
      int n;
      int b;
      logic [63:0] v;
      n  = (size == 2'd0) ? 1 : (size == 2'd1) ? 4 : (size == 2'd2) ? 2 : 8;
      b  = int'(addr % 64'(DEPTH));
      er = TRAP && ((b % n) != 0);
      rd = '0;
      if (er) return;
      if (we) begin
         for (int i = 0; i < n; i++) ref_mem[(b + i) % DEPTH] = 8'(wd >> (8 * (n - 1 - i)));
      end else begin
         v = '0;
         for (int i = 0; i < n; i++) v = (v << 8) | 64'(ref_mem[(b + i) % DEPTH]);
         if (!uns && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8 * n));
         rd = v;
      end
   endfunction

   // One clock: drive inputs, check ready before the edge, update model, check response after.
   task automatic step(input bit r, input bit v, input bit we, input logic [63:0] addr,
                       input logic [1:0] sz, input bit uns, input logic [63:0] wd,
                       input bit rdy);
      logic [63:0] rd;
      bit er;
      bit acc;
      rst              = r;
      bus.req_valid    = v;
      bus.req_we       = we;
      bus.req_addr     = addr;
      bus.req_size     = sz;
      bus.req_unsigned = uns;
      bus.req_wdata    = wd;
      bus.rsp_ready    = rdy;
      #1;
      chk("req_ready", 64'(bus.req_ready), 64'(!m_valid || rdy));
      acc = !r && v && (!m_valid || rdy);
      @(posedge clk);
      #1;
      if (r) begin
         m_valid = 1'b0;
         m_rdata = '0;
         m_err   = 1'b0;
      end else if (acc) begin
         ref_access(we, addr, sz, uns, wd, rd, er);
         m_valid = 1'b1;
         m_rdata = rd;
         m_err   = er;
      end else if (m_valid && rdy) begin
         m_valid = 1'b0;
      end
      chk("rsp_valid", 64'(bus.rsp_valid), 64'(m_valid));
      if (m_valid || r) begin
         chk("rsp_rdata", bus.rsp_rdata, m_rdata);
         chk("rsp_err", 64'(bus.rsp_err), 64'(m_err));
      end
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
      m_valid  = 1'b0;
      m_rdata  = '0;
      m_err    = 1'b0;
      n_assert = 0;
      n_fail   = 0;

      step(1, 0, 0, 0, 2'd0, 0, 0, 1);
      step(1, 0, 0, 0, 2'd0, 0, 0, 1);
      chk("reset_valid", 64'(bus.rsp_valid), 64'd0);
      chk("reset_rdata", bus.rsp_rdata, 64'd0);

      // 64-bit store/load, byte order
      step(0, 1, 1, 64'd8, 2'd3, 0, 64'h0102030405060708, 1);
      step(0, 1, 0, 64'd8, 2'd3, 0, 0, 1);
      chk("load64", bus.rsp_rdata, 64'h0102030405060708);
      step(0, 1, 0, 64'd8, 2'd0, 1, 0, 1);
      chk("byte8", bus.rsp_rdata, 64'h01);
      step(0, 1, 0, 64'd15, 2'd0, 1, 0, 1);
      chk("byte15", bus.rsp_rdata, 64'h08);

      // byte sign / zero extension
      step(0, 1, 1, 64'd54, 2'd0, 0, 64'h8B, 1);
      step(0, 1, 0, 64'd54, 2'd0, 0, 0, 1);
      chk("lb_signed", bus.rsp_rdata, 64'hFFFF_FFFF_FFFF_FF8B);
      step(0, 1, 0, 64'd54, 2'd0, 1, 0, 1);
      chk("lb_unsigned", bus.rsp_rdata, 64'h0000_0000_0000_008B);

      // half store, word load
      step(0, 1, 1, 64'd20, 2'd2, 0, 64'hBEEF, 1);
      step(0, 1, 0, 64'd20, 2'd1, 0, 0, 1);
      chk("lw_after_sh", bus.rsp_rdata, 64'hFFFF_FFFF_BEEF_0000);

      // back-to-back load, store, load
      step(0, 1, 0, 64'd20, 2'd1, 0, 0, 1);
      chk("b2b_ld1", bus.rsp_rdata, 64'hFFFF_FFFF_BEEF_0000);
      step(0, 1, 1, 64'd20, 2'd1, 0, 64'hCAFEF00D, 1);
      chk("b2b_st_valid", 64'(bus.rsp_valid), 64'd1);
      step(0, 1, 0, 64'd20, 2'd1, 1, 0, 1);
      chk("b2b_ld2", bus.rsp_rdata, 64'h0000_0000_CAFE_F00D);

      // backpressure holds the response; reset drops it and blocks the store
      step(0, 1, 0, 64'd8, 2'd3, 0, 0, 1);
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 1, 64'd8, 2'd3, 0, 64'hDEAD_BEEF_DEAD_BEEF, 0);
         chk("bp_ready", 64'(bus.req_ready), 64'd0);
         chk("bp_hold", bus.rsp_rdata, 64'h0102030405060708);
      end
      step(1, 1, 1, 64'd0, 2'd0, 0, 64'hAA, 0);
      chk("rst_drop", 64'(bus.rsp_valid), 64'd0);
      step(0, 1, 0, 64'd0, 2'd0, 1, 0, 1);
      chk("rst_nowrite", bus.rsp_rdata, 64'd0);

      // wrap across the top of memory
      step(0, 1, 1, 64'd62, 2'd0, 0, 64'h11, 1);
      step(0, 1, 1, 64'd63, 2'd0, 0, 64'h22, 1);
      step(0, 1, 1, 64'd0, 2'd0, 0, 64'h33, 1);
      step(0, 1, 1, 64'd1, 2'd0, 0, 64'h44, 1);
      step(0, 1, 0, 64'd62, 2'd1, 0, 0, 1);
      chk("wrap_rdata", bus.rsp_rdata, TRAP ? 64'd0 : 64'h0000_0000_1122_3344);
      chk("wrap_err", 64'(bus.rsp_err), TRAP ? 64'd1 : 64'd0);

      // upper address bits ignored
      step(0, 1, 0, 64'hFFFF_0000_0000_0048, 2'd3, 0, 0, 1);
      chk("addr_alias", bus.rsp_rdata, 64'h0102030405060708);

      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
              {$urandom, $urandom}, 2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
              {$urandom, $urandom}, $urandom_range(0, 3) != 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
